// File: rtl/ps2_pkg.sv
// PS/2 key decoder shared types: FSM states, prefix bytes, event layout
// and the scancode -> action-bit map.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam int         N_ACT       = 5;
  localparam int         EV_W        = 10;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_ev_t;

  // One-hot action bit for a scancode; all zero when the code is unmapped.
  function automatic logic [N_ACT-1:0] act_match(input logic [7:0] code);
    logic [N_ACT-1:0] m;
    m = '0;
    case (code)
      8'h4D:   m[0] = 1'b1;
      8'h2A:   m[1] = 1'b1;
      8'h22:   m[2] = 1'b1;
      8'h4B:   m[3] = 1'b1;
      8'h4C:   m[4] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO. Status flags come from a registered
// occupancy count, so a write shows up on empty the cycle after it lands.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until the count covers them.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw lines, deframes 11-bit
// frames, folds E0/F0 prefixes into flags, queues events and tracks a
// held/pulse bitmap for mapped keys.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_brk,
  output logic [N_ACT-1:0] act_held,
  output logic [N_ACT-1:0] act_pulse,
  output logic             frame_err,
  output logic             overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC + 2);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s, clk_d, fall;
  ps2_state_t             state, state_nx;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_q, par_ok;
  logic [TW-1:0]          tmo;
  logic                   tmo_hit, frame_ok, frame_bad;
  logic                   byte_vld;
  logic [7:0]             byte_q;
  logic                   ext_f, brk_f, is_ext, is_brk, push;
  logic [N_ACT-1:0]       act_hit;
  logic                   fifo_full, fifo_empty;
  logic [EV_W-1:0]        fifo_rd;
  ps2_ev_t                wr_ev, head;

  // Synchronisers idle high, matching released open-collector lines.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_d    <= clk_s;
    end
  end

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign fall    = clk_d & ~clk_s;
  assign tmo_hit = (tmo == TW'(TIMEOUT_CYC));

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shreg, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Frame sequencing; a stalled partial frame is abandoned as an error.
  always_comb begin
    state_nx  = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (fall) begin
      case (state)
        ST_IDLE:   if (!dat_s) state_nx = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        ST_PARITY: state_nx = ST_STOP;
        ST_STOP: begin
          state_nx = ST_IDLE;
          if (dat_s && par_ok) frame_ok  = 1'b1;
          else                 frame_bad = 1'b1;
        end
        default:   state_nx = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && tmo_hit) begin
      state_nx  = ST_IDLE;
      frame_bad = 1'b1;
    end
  end

  // Bit capture and inter-edge timeout counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      tmo     <= '0;
    end else begin
      if (state == ST_IDLE || fall) tmo <= '0;
      else                          tmo <= tmo + TW'(1);
      if (fall) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_q <= dat_s;
          default:   ;
        endcase
      end
    end
  end

  // Accepted byte is handled one cycle after the stop edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      byte_vld  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= frame_ok;
      frame_err <= frame_bad;
      if (frame_ok) byte_q <= shreg;
    end
  end

  assign is_ext = (byte_q == PS2_PFX_EXT);
  assign is_brk = (byte_q == PS2_PFX_BRK);
  assign push   = byte_vld & ~is_ext & ~is_brk;

  // Prefix flags accumulate until a real scancode consumes them.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (frame_bad) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (byte_vld) begin
      if (is_ext)      ext_f <= 1'b1;
      else if (is_brk) brk_f <= 1'b1;
      else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  assign wr_ev = '{code: byte_q, ext: ext_f, brk: brk_f};

  ps2_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .push    (push),
    .wr_data (wr_ev),
    .pop     (ev_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Dropped-event pulse: full with no simultaneous drain.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) overflow <= 1'b0;
    else       overflow <= push & fifo_full & ~(ev_ready & ~fifo_empty);
  end

  assign head     = ps2_ev_t'(fifo_rd);
  assign ev_valid = ~fifo_empty;
  assign ev_code  = ev_valid ? head.code : 8'h00;
  assign ev_ext   = ev_valid & head.ext;
  assign ev_brk   = ev_valid & head.brk;

  assign act_hit = act_match(byte_q);

  for (genvar g = 0; g < N_ACT; g++) begin : g_act
    logic held_r, pulse_r;
    // Per-action held level; pulse only on the 0->1 make, not on repeats.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        held_r  <= 1'b0;
        pulse_r <= 1'b0;
      end else begin
        pulse_r <= 1'b0;
        if (push && !ext_f && act_hit[g]) begin
          if (brk_f) held_r <= 1'b0;
          else begin
            held_r  <= 1'b1;
            pulse_r <= ~held_r;
          end
        end
      end
    end
    assign act_held[g]  = held_r;
    assign act_pulse[g] = pulse_r;
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks
// events, action bitmap, error/overflow pulses and reset behaviour.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int TMO   = 200;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic             ev_valid, ev_ready = 1'b1;
  logic [7:0]       ev_code;
  logic             ev_ext, ev_brk;
  logic [N_ACT-1:0] act_held, act_pulse;
  logic             frame_err, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int err_n = 0;
  int ovf_n = 0;
  int pls_n [N_ACT];
  logic [9:0] evq [$];
  logic [9:0] e;

  ps2_key_decoder #(
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TMO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_brk    (ev_brk),
    .act_held  (act_held),
    .act_pulse (act_pulse),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 Clk = ~Clk;

  initial for (int i = 0; i < N_ACT; i++) pls_n[i] = 0;

  // Observe at the falling edge: inputs were driven 2ns after the rising edge.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (ev_valid && ev_ready) evq.push_back({ev_code, ev_ext, ev_brk});
      if (frame_err) err_n++;
      if (overflow)  ovf_n++;
      for (int i = 0; i < N_ACT; i++) if (act_pulse[i]) pls_n[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic clr();
    evq.delete();
    err_n = 0;
    ovf_n = 0;
  endtask

  // Sends the first nbits of a frame; parity is odd unless flipped.
  task automatic send(input logic [7:0] b, input bit flip, input bit stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(20);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, 1'b0, 1'b1, 11);
  endtask

  task automatic pop_chk(input string tag, input logic [9:0] exp);
    if (evq.size() == 0) chk(tag, 32'hDEAD, {22'd0, exp});
    else begin
      e = evq.pop_front();
      chk(tag, {22'd0, e}, {22'd0, exp});
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_valid", {31'd0, ev_valid}, 0);
    chk("rst_code",  {24'd0, ev_code}, 0);
    chk("rst_held",  {27'd0, act_held}, 0);
    chk("rst_err",   {30'd0, frame_err, overflow}, 0);
    Reset = 1'b0;
    cyc(5);

    // Plain make of a mapped key
    clr();
    key(8'h4D);
    chk("mk_n", evq.size(), 1);
    pop_chk("mk_ev", {8'h4D, 2'b00});
    chk("mk_held", {27'd0, act_held}, 5'b00001);
    chk("mk_pulse", pls_n[0], 1);

    // Break via F0 prefix
    clr();
    key(8'hF0);
    key(8'h4D);
    chk("brk_n", evq.size(), 1);
    pop_chk("brk_ev", {8'h4D, 2'b01});
    chk("brk_held", {27'd0, act_held}, 5'b00000);

    // Make, extended code, typematic repeat
    clr();
    key(8'h4D);
    key(8'hE0);
    key(8'h4B);
    key(8'h4D);
    chk("ext_n", evq.size(), 3);
    pop_chk("ext_ev0", {8'h4D, 2'b00});
    pop_chk("ext_ev1", {8'h4B, 2'b10});
    pop_chk("ext_ev2", {8'h4D, 2'b00});
    chk("ext_held", {27'd0, act_held}, 5'b00001);
    chk("rep_pulse", pls_n[0], 2);
    chk("ext_pulse3", pls_n[3], 0);

    // Overflow with consumer stalled
    clr();
    ev_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) key(8'h1C);
    chk("ovf_valid", {31'd0, ev_valid}, 1);
    chk("ovf_head", {24'd0, ev_code}, 8'h1C);
    chk("ovf_cnt", ovf_n, 1);
    ev_ready = 1'b1;
    cyc(10);
    chk("drain_n", evq.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) pop_chk("drain_ev", {8'h1C, 2'b00});
    chk("drain_valid", {31'd0, ev_valid}, 0);

    // Bad parity
    clr();
    send(8'h1C, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err", err_n, 1);
    chk("par_n", evq.size(), 0);
`else
    chk("par_err", err_n, 0);
    chk("par_n", evq.size(), 1);
`endif

    // Bad stop bit
    clr();
    send(8'h1C, 1'b0, 1'b0, 11);
    chk("stop_err", err_n, 1);
    chk("stop_n", evq.size(), 0);

    // Stall after four data bits, then a clean frame
    clr();
    send(8'h2A, 1'b0, 1'b1, 5);
    cyc(TMO + 20);
    chk("tmo_err", err_n, 1);
    chk("tmo_n", evq.size(), 0);
    chk("tmo_valid", {31'd0, ev_valid}, 0);
    key(8'h2A);
    pop_chk("tmo_next", {8'h2A, 2'b00});
    chk("tmo_held", {27'd0, act_held}, 5'b00011);
    chk("tmo_pulse1", pls_n[1], 1);

    // Reset in the middle of a frame
    clr();
    send(8'h4B, 1'b0, 1'b1, 6);
    Reset = 1'b1;
    #3;
    chk("mrst_held", {27'd0, act_held}, 0);
    chk("mrst_out", {20'd0, ev_valid, ev_code, ev_ext, ev_brk, frame_err}, 0);
    chk("mrst_pls", {27'd0, act_pulse}, 0);
    cyc(3);
    Reset = 1'b0;
    cyc(5);
    key(8'h4B);
    chk("mrst_n", evq.size(), 1);
    pop_chk("mrst_ev", {8'h4B, 2'b00});
    chk("mrst_held2", {27'd0, act_held}, 5'b01000);
    chk("mrst_err", err_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for ps2_clk/ps2_data (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, Clk cycles without a PS/2 falling edge before a partial frame is aborted.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, min 2).
REQ-004 SHALL have port Clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports ps2_clk, ps2_data  input  1 each  raw asynchronous PS/2 lines.
REQ-007 SHALL have port ev_valid  output  1  FIFO non-empty; head event presented.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts head when ev_valid&&ev_ready.
REQ-009 SHALL have ports ev_code [7:0], ev_ext [1], ev_brk [1]  output  head scancode, E0-prefixed flag, F0-prefixed (release) flag.
REQ-010 SHALL have port act_held  output  [N_ACT-1:0]  level bitmap of mapped keys currently pressed.
REQ-011 SHALL have port act_pulse  output  [N_ACT-1:0]  one-cycle pulse on a mapped key's first make.
REQ-012 SHALL have ports frame_err, overflow  output  1 each  one-cycle error pulses.

Function
REQ-013 SHALL pass both pins through SYNC_STAGES flops; falling edge = synced ps2_clk 1->0, detected one cycle after the last sync stage.
REQ-014 SHALL run FSM IDLE->DATA->PARITY->STOP, advancing only on a detected falling edge, sampling synced ps2_data.
REQ-015 IDLE: data 0 -> DATA with bit count 0; data 1 -> stay IDLE, no error.
REQ-016 DATA: shift 8 bits LSB first; after bit 7 -> PARITY; PARITY: capture bit -> STOP.
REQ-017 STOP: frame valid iff stop bit = 1 (and parity check per REQ-029); always return to IDLE.
REQ-018 Invalid stop bit or timeout in non-IDLE state SHALL pulse frame_err, return to IDLE, clear prefix flags.
REQ-019 Timeout counter SHALL reset on every falling edge and hold 0 in IDLE.
REQ-020 Valid byte 0xE0 SHALL set ext flag, 0xF0 SHALL set brk flag; neither is pushed.
REQ-021 Any other valid byte SHALL push {code, ext, brk} into FIFO and clear both flags in the same cycle.
REQ-022 Push SHALL occur the cycle after the stop-bit edge; ev_valid rises the following cycle at the earliest (registered status).
REQ-023 FIFO is first-word-fall-through; ev_code/ev_ext/ev_brk are stable while ev_valid && !ev_ready.
REQ-024 Push when full and no pop: event dropped, overflow pulses; push+pop in same cycle when full: push accepted, no overflow.
REQ-025 Non-extended event whose code matches the package action map: make sets act_held bit and pulses act_pulse only if the bit was 0 (typematic repeats do not pulse); break clears bit.
REQ-026 act_held/act_pulse SHALL update at the push cycle, independent of FIFO fullness; extended codes never touch them.

Reset
REQ-027 Reset SHALL asynchronously force: FSM IDLE, counters 0, prefix flags 0, FIFO empty, sync flops 1.
REQ-028 Outputs under reset: ev_valid 0, ev_code 0, ev_ext 0, ev_brk 0, act_held 0, act_pulse 0, frame_err 0, overflow 0; a frame in flight is discarded.

Configuration
REQ-029 Macro PS2_PARITY_CHECK_EN defined: frame valid additionally requires odd parity over 8 data bits + parity bit, else frame_err; undefined: parity bit captured and ignored.

Structure
REQ-030 Package ps2_pkg SHALL hold FSM state enum, PS2_PFX_EXT=0xE0, PS2_PFX_BRK=0xF0, N_ACT=5, and action map 0x4D->0, 0x2A->1, 0x22->2, 0x4B->3, 0x4C->4.
REQ-031 FIFO SHALL be sub-module ps2_event_fifo (width 10, depth FIFO_DEPTH, FWFT, full/empty flags).

Verification
REQ-032 Frame 0x4D, parity 1, stop 1, ev_ready=1 -> one event code 0x4D ext 0 brk 0; act_held=00001; act_pulse=00001 for one cycle.
REQ-033 Sequence F0, 4D -> one event 0x4D brk 1; act_held=00000; no event for F0.
REQ-034 E0, 4B -> event 0x4B ext 1; act_held unchanged; repeat 0x4D make while held -> event pushed, no act_pulse.
REQ-035 ev_ready=0, FIFO_DEPTH+1 frames of 0x1C (parity 0) -> ev_valid 1, overflow pulses once, then draining yields exactly FIFO_DEPTH events in order.
REQ-036 0x1C with parity 1 -> frame_err and no event when PS2_PARITY_CHECK_EN defined; event pushed when undefined; stop bit 0 -> frame_err either way.
REQ-037 Stop clocking after 4 data bits for TIMEOUT_CYC+2 cycles -> frame_err, FIFO unchanged; next clean 0x2A frame decodes; Reset asserted mid-frame -> all outputs 0.
